// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Produces operand forwarding selects, load-use and HI/LO interlocks,
// sequences the multi-cycle mul/div unit and defers branch/jump squashes
// that arrive while ID is stalled.
//
// Mul/div sequencer states:
//   state  | meaning
//   S_IDLE | unit free; a mult/div advancing out of ID launches it
//   S_BUSY | unit occupied; r_cnt counts remaining busy cycles down to 1
module hazard_md_ctrl #(
   parameter int unsigned MUL_CYCLES = 3,
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_reg_a_valid,
   input  logic       id_reg_b_valid,
   input  logic       id_md_start,
   input  logic       id_md_is_div,
   input  logic       id_md_read,
   input  logic       ex_valid,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_waddr,
   input  logic       mem_valid,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_waddr,
   input  logic       ex_jump_taken,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       stall_id,
   output logic       bubble_ex,
   output logic       flush_if,
   output logic       md_start,
   output logic       md_is_div,
   output logic       md_busy,
   output logic       md_done
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   localparam logic [5:0] LP_MUL_CNT = 6'(MUL_CYCLES);
   localparam logic [5:0] LP_DIV_CNT = 6'(DIV_CYCLES);

   md_state_t  r_state;
   md_state_t  w_state_nxt;
   logic [5:0] r_cnt;
   logic [5:0] w_cnt_nxt;
   logic       r_md_done;
   logic       w_md_done_nxt;
   logic       r_redirect_pending;
   logic       w_redirect_pending_nxt;

   logic       w_ex_wr;
   logic       w_mem_wr;
   logic       w_ex_match_a;
   logic       w_ex_match_b;
   logic       w_mem_match_a;
   logic       w_mem_match_b;
   logic       w_load_use;
   logic       w_md_conflict;
   logic       w_stall;
   logic       w_advance;
   logic       w_md_start;
   logic       w_md_is_div;

   // A stage can only be a forwarding source if it really writes a nonzero register.
   assign w_ex_wr  = ex_valid & ex_reg_write & (ex_waddr != 5'd0);
   assign w_mem_wr = mem_valid & mem_reg_write & (mem_waddr != 5'd0);

   assign w_ex_match_a  = w_ex_wr  & id_reg_a_valid & (ex_waddr  == id_rs);
   assign w_ex_match_b  = w_ex_wr  & id_reg_b_valid & (ex_waddr  == id_rt);
   assign w_mem_match_a = w_mem_wr & id_reg_a_valid & (mem_waddr == id_rs);
   assign w_mem_match_b = w_mem_wr & id_reg_b_valid & (mem_waddr == id_rt);

   // Forwarding selects: the younger EX result wins unless it is a load still in flight.
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (w_ex_match_a && !ex_mem_read) begin
         fwd_a_sel = 2'b01;
      end else if (w_mem_match_a) begin
         fwd_a_sel = 2'b10;
      end
      if (w_ex_match_b && !ex_mem_read) begin
         fwd_b_sel = 2'b01;
      end else if (w_mem_match_b) begin
         fwd_b_sel = 2'b10;
      end
   end

   assign w_load_use    = (w_ex_match_a | w_ex_match_b) & ex_mem_read;
   assign w_md_conflict = id_valid & (id_md_start | id_md_read) & md_busy;
   assign w_stall       = w_load_use | w_md_conflict;
   assign w_advance     = id_valid & ~w_stall;

   assign stall_id  = w_stall;
   assign bubble_ex = w_stall;

   // Sequencer state, busy counter, done pulse and deferred-redirect flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state            <= S_IDLE;
         r_cnt              <= 6'd0;
         r_md_done          <= 1'b0;
         r_redirect_pending <= 1'b0;
      end else begin
         r_state            <= w_state_nxt;
         r_cnt              <= w_cnt_nxt;
         r_md_done          <= w_md_done_nxt;
         r_redirect_pending <= w_redirect_pending_nxt;
      end
   end

   // Mul/div next state: launch only from IDLE, done is raised on the last busy cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_md_done_nxt = 1'b0;
      w_md_start    = 1'b0;
      w_md_is_div   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_advance && id_md_start) begin
               w_md_start  = 1'b1;
               w_md_is_div = id_md_is_div;
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = id_md_is_div ? LP_DIV_CNT : LP_MUL_CNT;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
               w_state_nxt   = S_IDLE;
               w_md_done_nxt = 1'b1;
            end
         end
      endcase
   end

   assign md_start  = w_md_start;
   assign md_is_div = w_md_is_div;
   assign md_busy   = (r_state == S_BUSY);
   assign md_done   = r_md_done;

   // A redirect seen during a stall is remembered and released exactly once when ID moves;
   // the delay slot sitting in ID is untouched because only IF/ID input is flushed.
   always_comb begin
      w_redirect_pending_nxt = 1'b0;
      if (w_stall) begin
         w_redirect_pending_nxt = r_redirect_pending | ex_jump_taken;
      end
   end

   assign flush_if = (ex_jump_taken | r_redirect_pending) & ~w_stall;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Directed testbench for hazard_md_ctrl. A second instance with MUL_CYCLES=1
// covers the single-cycle mul/div boundary; it shares all inputs.
module tb_hazard_md_ctrl;

   logic       clk;
   logic       resetn;
   logic       id_valid;
   logic [4:0] id_rs, id_rt;
   logic       id_reg_a_valid, id_reg_b_valid;
   logic       id_md_start, id_md_is_div, id_md_read;
   logic       ex_valid, ex_reg_write, ex_mem_read;
   logic [4:0] ex_waddr;
   logic       mem_valid, mem_reg_write;
   logic [4:0] mem_waddr;
   logic       ex_jump_taken;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall_id, bubble_ex, flush_if;
   logic       md_start, md_is_div, md_busy, md_done;
   logic [1:0] u1_fwd_a_sel, u1_fwd_b_sel;
   logic       u1_stall_id, u1_bubble_ex, u1_flush_if;
   logic       u1_md_start, u1_md_is_div, u1_md_busy, u1_md_done;

   int n_chk = 0;
   int n_err = 0;

   hazard_md_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(33)) dut (
      .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_reg_a_valid(id_reg_a_valid), .id_reg_b_valid(id_reg_b_valid),
      .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .id_md_read(id_md_read),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_waddr(ex_waddr), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_waddr(mem_waddr), .ex_jump_taken(ex_jump_taken),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_id(stall_id),
      .bubble_ex(bubble_ex), .flush_if(flush_if), .md_start(md_start),
      .md_is_div(md_is_div), .md_busy(md_busy), .md_done(md_done));

   hazard_md_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(2)) dut1 (
      .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_reg_a_valid(id_reg_a_valid), .id_reg_b_valid(id_reg_b_valid),
      .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .id_md_read(id_md_read),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_waddr(ex_waddr), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_waddr(mem_waddr), .ex_jump_taken(ex_jump_taken),
      .fwd_a_sel(u1_fwd_a_sel), .fwd_b_sel(u1_fwd_b_sel), .stall_id(u1_stall_id),
      .bubble_ex(u1_bubble_ex), .flush_if(u1_flush_if), .md_start(u1_md_start),
      .md_is_div(u1_md_is_div), .md_busy(u1_md_busy), .md_done(u1_md_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_rs = 0; id_rt = 0; id_reg_a_valid = 0; id_reg_b_valid = 0;
      id_md_start = 0; id_md_is_div = 0; id_md_read = 0;
      ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_waddr = 0;
      mem_valid = 0; mem_reg_write = 0; mem_waddr = 0; ex_jump_taken = 0;
   endtask

   task automatic test_reset();
      resetn = 0;
      clear_inputs();
      #2;
      n_chk++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", md_busy); end
      n_chk++; if (md_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", md_done); end
      n_chk++; if (md_start !== 1'b0 || md_is_div !== 1'b0) begin n_err++; $display("FAIL reset_start got %b/%b exp 0/0", md_start, md_is_div); end
      n_chk++; if (flush_if !== 1'b0 || stall_id !== 1'b0) begin n_err++; $display("FAIL reset_flush_stall got %b/%b exp 0/0", flush_if, stall_id); end
      ex_jump_taken = 1;
      #1;
      n_chk++; if (flush_if !== 1'b1) begin n_err++; $display("FAIL reset_flush_jump got %b exp 1", flush_if); end
      ex_jump_taken = 0;
      ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5'd9;
      id_valid = 1; id_rs = 5'd9; id_reg_a_valid = 1;
      #1;
      n_chk++; if (stall_id !== 1'b1 || bubble_ex !== 1'b1) begin n_err++; $display("FAIL reset_stall_comb got %b/%b exp 1/1", stall_id, bubble_ex); end
      clear_inputs();
      step();
      step();
      resetn = 1;
      step();
   endtask

   task automatic test_forwarding();
      clear_inputs();
      id_valid = 1;
      ex_valid = 1; ex_reg_write = 1; ex_waddr = 5'd8;
      mem_valid = 1; mem_reg_write = 1; mem_waddr = 5'd8;
      id_rs = 5'd8; id_reg_a_valid = 1;
      id_rt = 5'd8; id_reg_b_valid = 1;
      #1;
      n_chk++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL fwd_ex_prio_a got %b exp 01", fwd_a_sel); end
      n_chk++; if (fwd_b_sel !== 2'b01) begin n_err++; $display("FAIL fwd_ex_prio_b got %b exp 01", fwd_b_sel); end
      n_chk++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL fwd_no_stall got %b exp 0", stall_id); end
      ex_valid = 0;
      #1;
      n_chk++; if (fwd_a_sel !== 2'b10) begin n_err++; $display("FAIL fwd_mem_a got %b exp 10", fwd_a_sel); end
      id_rs = 5'd0;
      #1;
      n_chk++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin n_err++; $display("FAIL fwd_rs0 got %b/%b exp 00/10", fwd_a_sel, fwd_b_sel); end
      mem_waddr = 5'd0; id_rt = 5'd0;
      ex_valid = 1; ex_waddr = 5'd0;
      #1;
      n_chk++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_r0_never got %b exp 00", fwd_b_sel); end
      ex_waddr = 5'd12; id_rt = 5'd12; id_reg_b_valid = 0;
      #1;
      n_chk++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_src_invalid got %b exp 00", fwd_b_sel); end
      id_reg_b_valid = 1; ex_reg_write = 0;
      #1;
      n_chk++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_no_regwrite got %b exp 00", fwd_b_sel); end
      clear_inputs();
      step();
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5'd8;
      id_valid = 1; id_rt = 5'd8; id_reg_b_valid = 1; id_rs = 5'd3; id_reg_a_valid = 1;
      #1;
      n_chk++; if (stall_id !== 1'b1 || bubble_ex !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b/%b exp 1/1", stall_id, bubble_ex); end
      step();
      ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_waddr = 0;
      mem_valid = 1; mem_reg_write = 1; mem_waddr = 5'd8;
      #1;
      n_chk++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL lu_release got %b exp 0", stall_id); end
      n_chk++; if (fwd_b_sel !== 2'b10 || fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL lu_fwd got %b/%b exp 10/00", fwd_b_sel, fwd_a_sel); end
      clear_inputs();
      step();
   endtask

   task automatic test_divide();
      clear_inputs();
      id_valid = 1; id_md_start = 1; id_md_is_div = 1;
      #1;
      n_chk++; if (md_start !== 1'b1 || md_is_div !== 1'b1) begin n_err++; $display("FAIL div_launch got %b/%b exp 1/1", md_start, md_is_div); end
      n_chk++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL div_busy_T got %b exp 0", md_busy); end
      step();
      id_md_start = 0; id_md_is_div = 0; id_md_read = 1;
      for (int k = 1; k <= 33; k++) begin
         #1;
         n_chk++; if (md_busy !== 1'b1 || md_done !== 1'b0) begin n_err++; $display("FAIL div_busy k=%0d got busy %b done %b exp 1/0", k, md_busy, md_done); end
         n_chk++; if (stall_id !== 1'b1 || md_start !== 1'b0 || md_is_div !== 1'b0) begin n_err++; $display("FAIL div_mflo_hold k=%0d got stall %b start %b isdiv %b exp 1/0/0", k, stall_id, md_start, md_is_div); end
         step();
      end
      #1;
      n_chk++; if (md_busy !== 1'b0 || md_done !== 1'b1) begin n_err++; $display("FAIL div_done got busy %b done %b exp 0/1", md_busy, md_done); end
      n_chk++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL div_mflo_adv got %b exp 0", stall_id); end
      step();
      clear_inputs();
      #1;
      n_chk++; if (md_done !== 1'b0) begin n_err++; $display("FAIL div_done_pulse got %b exp 0", md_done); end
      step();
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      id_valid = 1; id_md_start = 1;
      #1;
      n_chk++; if (md_start !== 1'b1 || md_is_div !== 1'b0) begin n_err++; $display("FAIL b2b_first got %b/%b exp 1/0", md_start, md_is_div); end
      step();
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_chk++; if (stall_id !== 1'b1 || md_start !== 1'b0 || md_busy !== 1'b1) begin n_err++; $display("FAIL b2b_hold k=%0d got stall %b start %b busy %b exp 1/0/1", k, stall_id, md_start, md_busy); end
         step();
      end
      #1;
      n_chk++; if (md_start !== 1'b1 || md_done !== 1'b1 || stall_id !== 1'b0) begin n_err++; $display("FAIL b2b_second got start %b done %b stall %b exp 1/1/0", md_start, md_done, stall_id); end
      step();
      clear_inputs();
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_chk++; if (md_busy !== 1'b1 || md_done !== 1'b0) begin n_err++; $display("FAIL b2b_busy2 k=%0d got %b/%b exp 1/0", k, md_busy, md_done); end
         step();
      end
      #1;
      n_chk++; if (md_done !== 1'b1 || md_busy !== 1'b0) begin n_err++; $display("FAIL b2b_done2 got %b/%b exp 1/0", md_done, md_busy); end
      step();
   endtask

   task automatic test_mul_one_cycle();
      clear_inputs();
      id_valid = 1; id_md_start = 1;
      #1;
      n_chk++; if (u1_md_start !== 1'b1) begin n_err++; $display("FAIL n1_start got %b exp 1", u1_md_start); end
      step();
      clear_inputs();
      #1;
      n_chk++; if (u1_md_busy !== 1'b1 || u1_md_done !== 1'b0) begin n_err++; $display("FAIL n1_busy got %b/%b exp 1/0", u1_md_busy, u1_md_done); end
      step();
      #1;
      n_chk++; if (u1_md_busy !== 1'b0 || u1_md_done !== 1'b1) begin n_err++; $display("FAIL n1_done got %b/%b exp 0/1", u1_md_busy, u1_md_done); end
      step();
      #1;
      n_chk++; if (u1_md_done !== 1'b0) begin n_err++; $display("FAIL n1_done_pulse got %b exp 0", u1_md_done); end
      step();
      step();
   endtask

   task automatic test_simultaneous();
      clear_inputs();
      id_valid = 1; id_md_start = 1;
      step();
      id_md_start = 0; id_md_read = 1; id_rs = 5'd4; id_reg_a_valid = 1;
      ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5'd4;
      #1;
      n_chk++; if (stall_id !== 1'b1 || bubble_ex !== 1'b1) begin n_err++; $display("FAIL sim_both got %b/%b exp 1/1", stall_id, bubble_ex); end
      step();
      ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_waddr = 0;
      #1;
      n_chk++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL sim_md_only got %b exp 1", stall_id); end
      step();
      step();
      ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5'd4;
      #1;
      n_chk++; if (md_busy !== 1'b0 || stall_id !== 1'b1) begin n_err++; $display("FAIL sim_lu_only got busy %b stall %b exp 0/1", md_busy, stall_id); end
      ex_mem_read = 0;
      #1;
      n_chk++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL sim_release got %b exp 0", stall_id); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_redirect();
      clear_inputs();
      ex_jump_taken = 1;
      #1;
      n_chk++; if (flush_if !== 1'b1) begin n_err++; $display("FAIL rd_plain got %b exp 1", flush_if); end
      step();
      ex_jump_taken = 0;
      #1;
      n_chk++; if (flush_if !== 1'b0) begin n_err++; $display("FAIL rd_plain_once got %b exp 0", flush_if); end
      step();
      ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5'd8;
      id_valid = 1; id_rt = 5'd8; id_reg_b_valid = 1; ex_jump_taken = 1;
      #1;
      n_chk++; if (flush_if !== 1'b0 || stall_id !== 1'b1) begin n_err++; $display("FAIL rd_lu_defer got flush %b stall %b exp 0/1", flush_if, stall_id); end
      step();
      ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_waddr = 0; ex_jump_taken = 0;
      #1;
      n_chk++; if (flush_if !== 1'b1) begin n_err++; $display("FAIL rd_lu_release got %b exp 1", flush_if); end
      step();
      #1;
      n_chk++; if (flush_if !== 1'b0) begin n_err++; $display("FAIL rd_lu_once got %b exp 0", flush_if); end
      step();
      clear_inputs();
      id_valid = 1; id_md_start = 1;
      step();
      id_md_start = 0; id_md_read = 1; ex_jump_taken = 1;
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_chk++; if (flush_if !== 1'b0) begin n_err++; $display("FAIL rd_md_defer k=%0d got %b exp 0", k, flush_if); end
         step();
         ex_jump_taken = 0;
      end
      #1;
      n_chk++; if (flush_if !== 1'b1 || stall_id !== 1'b0) begin n_err++; $display("FAIL rd_md_release got flush %b stall %b exp 1/0", flush_if, stall_id); end
      step();
      clear_inputs();
      #1;
      n_chk++; if (flush_if !== 1'b0) begin n_err++; $display("FAIL rd_md_once got %b exp 0", flush_if); end
      step();
   endtask

   task automatic test_reset_mid_div();
      int done_seen;
      clear_inputs();
      id_valid = 1; id_md_start = 1; id_md_is_div = 1;
      step();
      clear_inputs();
      for (int k = 1; k < 10; k++) step();
      #1;
      n_chk++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before got %b exp 1", md_busy); end
      resetn = 0;
      #1;
      n_chk++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b/%b exp 0/0", md_busy, md_done); end
      step();
      step();
      resetn = 1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (md_done !== 1'b0 || md_busy !== 1'b0) done_seen++;
      end
      n_chk++; if (done_seen != 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d active cycles exp 0", done_seen); end
      id_valid = 1; id_md_start = 1;
      #1;
      n_chk++; if (md_start !== 1'b1 || md_is_div !== 1'b0) begin n_err++; $display("FAIL rst_mid_relaunch got %b/%b exp 1/0", md_start, md_is_div); end
      step();
      clear_inputs();
      step(); step(); step();
      #1;
      n_chk++; if (md_done !== 1'b1 || md_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_mul_done got %b/%b exp 1/0", md_done, md_busy); end
      step();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_divide();
      test_back_to_back();
      test_mul_one_cycle();
      test_simultaneous();
      test_redirect();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_md_ctrl.md
# hazard_md_ctrl

- Central pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID/EX pipe register.
- Computes per-operand forwarding selects and load-use interlocks.
- Sequences the multi-cycle mul/div unit (start pulse, busy count, done pulse) and stalls HI/LO consumers.
- Tracks branch/jump redirects from EX so the wrong-path fetch is squashed exactly once, even across stalls.

## Interface
Parameters:
- MUL_CYCLES, 3, busy cycles for a multiply; legal 1..63
- DIV_CYCLES, 33, busy cycles for a divide; legal 1..63

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers (inst[25:21], inst[20:16])
- id_reg_a_valid, id_reg_b_valid  in  1 each  instruction reads rs / rt
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_is_div  in  1  qualifies id_md_start: 1 = divide
- id_md_read  in  1  ID instruction reads HI/LO (mfhi/mflo)
- ex_valid, ex_reg_write, ex_mem_read  in  1 each  EX stage status
- ex_waddr  in  5  EX destination register
- mem_valid, mem_reg_write  in  1 each  MEM stage status
- mem_waddr  in  5  MEM destination register
- ex_jump_taken  in  1  branch/jump resolved taken in EX
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 EX result, 10 MEM result
- stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_if  out  1  invalidate the instruction entering IF/ID
- md_start  out  1  one-cycle launch pulse to mul/div unit
- md_is_div  out  1  operation type, valid with md_start
- md_busy  out  1  mul/div unit occupied
- md_done  out  1  one-cycle pulse: HI/LO now valid

## Operation
Register matching:
- A match requires the stage to be valid, have reg_write set, a nonzero waddr, and a source-valid bit set for that operand.
- Register 0 never matches.

Forwarding (combinational):
- EX match with !ex_mem_read selects 01.
- Otherwise a MEM match selects 10 (includes load data).
- Otherwise 00.
- EX has priority over MEM.

Load-use:
- Triggered by an EX match with ex_mem_read on either operand.

md_conflict:
- Triggered by id_valid & (id_md_start | id_md_read) & md_busy.

Stalls:
- stall_id = bubble_ex = load-use | md_conflict.

Advance:
- advance = id_valid & !stall_id.

Mul/div FSM, states IDLE and BUSY, with a 6-bit down-counter cnt:
- IDLE: if advance & id_md_start, drive md_start=1 and md_is_div=id_md_is_div. Next state BUSY; cnt loads DIV_CYCLES if divide, else MUL_CYCLES.
- BUSY: cnt decrements each cycle. When cnt==1, next state is IDLE and the md_done register is set for one cycle.
- md_busy = (state==BUSY).
- md_start is combinational and only asserted from IDLE. md_is_div is 0 whenever md_start is 0.

Redirect:
- flush_if = (ex_jump_taken & !stall_id) | (redirect_pending & !stall_id).
- redirect_pending sets on ex_jump_taken & stall_id and clears on the first cycle stall_id is 0.
- The delay-slot instruction in ID is never flushed.

## Timing
- Reset (asynchronous, any time including mid-operation): state IDLE, cnt 0, md_done 0, redirect_pending 0. An in-flight mul/div is abandoned with no md_done.
- Reset output values: md_busy 0, md_done 0, md_start 0, md_is_div 0. flush_if 0 unless ex_jump_taken; stall/fwd outputs follow the inputs combinationally.
- Mul/div launched in cycle T: md_busy is high in cycles T+1..T+N (N = programmed cycles); md_done is high in T+N+1 only.
- mfhi/mflo entering ID in T+1..T+N is held. It advances in T+N+1 at the earliest.
- N=1: md_busy for one cycle, md_done in T+2.
- Back-to-back mult/div in ID is held while busy; the second launch occurs in T+N+1. md_done and the second md_start may coincide.
- Load-use: exactly one stall cycle. After that the load is in MEM and the operand forwards with sel 10.
- Simultaneous load-use and md_conflict: a single stall_id; both must clear before advance.
- ex_jump_taken during a stall: flush_if is deferred and asserted exactly once, in the release cycle.

## Test plan
- Forwarding priority: EX (waddr 8, reg_write) and MEM (waddr 8) both valid, id_rs=8 -> fwd_a_sel=01. Remove EX -> 10. Set id_rs=0 -> 00.
- Load-use: lw $t0 in EX, ID reads rt=8 -> stall_id=bubble_ex=1 for one cycle, then fwd_b_sel=10 and no stall.
- Divide: div advances at T with DIV_CYCLES=33 -> md_start pulse at T with md_is_div=1; md_busy T+1..T+33; md_done only at T+34. mflo in ID from T+1 is stalled until T+34.
- Multiply back-to-back: mult at T, mult in ID at T+1 (MUL_CYCLES=3) -> stall T+1..T+3; second md_start at T+4 coincident with md_done.
- Redirect under stall: ex_jump_taken while load-use stalls -> flush_if=0 that cycle, 1 for one cycle on release, never again.
- Reset mid-divide: deassert resetn at T+10 -> md_busy=0 immediately. After release, no md_done; a new mult launches normally.
